serial_adder_ctrl: RTL and testbench

Bit-serial adder controller: sequences a single one-bit full-adder cell over a WIDTH-bit operand pair, LSB first, one bit per clock, with the carry held in a flip-flop between bits. Replaces a WIDTH-wide ripple adder where area matters more than latency. Sits between a requester issuing start/operands and a consumer sampling done/sum.

---
 rtl/serial_adder_ctrl_if.sv | 35 +++
 rtl/serial_adder_ctrl.sv | 94 +++++++++
 tb/tb_serial_adder_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle for the bit-serial adder controller.
// The sub field exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  serial_adder_ctrl_if.slave io
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    cnt;
  logic             sub_l;
  logic             s;
  logic             co;
  logic             last;
  logic             accept;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_l = io.sub;
`else
  assign sub_l = 1'b0;
`endif

  assign s      = ra[0] ^ rb[0] ^ carry;
  assign co     = (ra[0] & rb[0]) | (rb[0] & carry) | (ra[0] & carry);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = (state == IDLE) && io.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (io.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra     <= '0;
      rb     <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          ra     <= io.a;
          rb     <= sub_l ? ~io.b : io.b;
          carry  <= sub_l ? 1'b1 : io.cin;
          sum_q  <= '0;
          cout_q <= 1'b0;
          cnt    <= '0;
        end
        (state == RUN): begin
          sum_q <= {s, sum_q[WIDTH-1:1]};
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          carry <= co;
          cnt   <= cnt + CW'(1);
          // final carry goes straight to cout on the last bit
          if (last) cout_q <= co;
        end
        default: ;
      endcase
    end
  end

  assign io.busy = (state == RUN);
  assign io.done = (state == DONE);
  assign io.sum  = sum_q;
  assign io.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: vector table, random ops vs model,
// and hand-written reset / back-to-back / start-hold sequences.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [8:0] ref_op(input logic [7:0] a, b,
                                        input logic ci, su);
    logic [8:0] r;
    if (su) r = {1'b0, a} + {1'b0, ~b} + 9'd1;
    else    r = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    return r;
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy && bus.done) begin
        errors++;
        $display("FAIL busy_done_overlap got 1 expected 0");
      end
    end
  endtask

  task automatic do_op(input logic [7:0] a, b, input logic ci, su,
                       output logic [8:0] res, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = ci;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = su;
`endif
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    bus.cin   = 1'($urandom);
    chk("busy_after_start", {63'd0, bus.busy}, 64'd1);
    wait_done(lat);
    res = {bus.cout, bus.sum};
    @(posedge clk);
    #1;
    chk("done_single_cycle", {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [8:0] res;
    logic [8:0] exp;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic       rs;
    int         lat;
    int         ndone;
    int         last_cyc;
    int         nb2b;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif

    tbl.push_back({8'h5A, 8'h33, 1'b0, 1'b0, 9'h08D});
    tbl.push_back({8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF});
    tbl.push_back({8'hFF, 8'h01, 1'b0, 1'b0, 9'h100});
    tbl.push_back({8'h10, 8'h20, 1'b0, 1'b0, 9'h030});
    tbl.push_back({8'h00, 8'h00, 1'b1, 1'b0, 9'h001});
    tbl.push_back({8'h80, 8'h80, 1'b0, 1'b0, 9'h100});
    tbl.push_back({8'h00, 8'h00, 1'b0, 1'b0, 9'h000});
`ifdef SERIAL_ADDER_SUB_EN
    tbl.push_back({8'h10, 8'h01, 1'b0, 1'b1, 9'h10F});
    tbl.push_back({8'h01, 8'h02, 1'b1, 1'b1, 9'h0FF});
    tbl.push_back({8'h42, 8'h42, 1'b0, 1'b1, 9'h100});
`endif

    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_sum", {56'd0, bus.sum}, 64'd0);
    chk("rst_cout", {63'd0, bus.cout}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, res, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd8);
      chk($sformatf("vec%0d_result", i), {55'd0, res},
          {55'd0, tbl[i].exp});
      if (i == 0) begin
        for (int k = 0; k < 5; k++) begin
          @(posedge clk);
          #1;
          chk("hold_sum", {56'd0, bus.sum}, 64'h8D);
          chk("hold_cout", {63'd0, bus.cout}, 64'd0);
          chk("hold_no_done", {63'd0, bus.done}, 64'd0);
        end
      end
    end

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      exp = ref_op(ra, rb, rc, rs);
      do_op(ra, rb, rc, rs, res, lat);
      chk("rand_latency", 64'(lat), 64'd8);
      chk($sformatf("rand%0d_%0h_%0h_%0b_%0b", i, ra, rb, rc, rs),
          {55'd0, res}, {55'd0, exp});
    end

    // start held high while operands change during RUN
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h01;
    bus.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif
    @(posedge clk);
    #1;
    bus.a = 8'hF0;
    wait_done(lat);
    chk("hold_start_latency", 64'(lat), 64'd8);
    chk("hold_start_sum", {56'd0, bus.sum}, 64'h02);
    chk("hold_start_cout", {63'd0, bus.cout}, 64'd0);
    @(posedge clk);
    #1;
    chk("hold_start_idle_busy", {63'd0, bus.busy}, 64'd0);
    chk("hold_start_idle_done", {63'd0, bus.done}, 64'd0);
    @(posedge clk);
    #1;
    chk("hold_start_reaccept", {63'd0, bus.busy}, 64'd1);
    bus.start = 1'b0;
    wait_done(lat);
    chk("hold_start_second_sum", {56'd0, bus.sum}, 64'hF1);
    @(posedge clk);
    #1;

    // reset in the middle of RUN
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h77;
    bus.b     = 8'h11;
    bus.cin   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
    chk("midrst_done", {63'd0, bus.done}, 64'd0);
    chk("midrst_sum", {56'd0, bus.sum}, 64'd0);
    chk("midrst_cout", {63'd0, bus.cout}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    chk("midrst_no_done", 64'(ndone), 64'd0);
    do_op(8'h10, 8'h20, 1'b0, 1'b0, res, lat);
    chk("post_rst_result", {55'd0, res}, 64'h030);

    // back-to-back with start held continuously
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h03;
    bus.b     = 8'h04;
    bus.cin   = 1'b0;
    last_cyc  = -1;
    nb2b      = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        chk("b2b_sum", {56'd0, bus.sum}, 64'h07);
        if (last_cyc >= 0)
          chk("b2b_interval", 64'(c - last_cyc), 64'd10);
        last_cyc = c;
        nb2b++;
      end
    end
    bus.start = 1'b0;
    chk("b2b_count", 64'(nb2b), 64'd4);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
